// File: rtl/life_gen_sequencer.sv
// Sequences one Game-of-Life generation: streams a toroidal 3-row window out of the
// active bank, writes result rows into the other bank, then swaps banks and scores the game.
module life_gen_sequencer #(
   parameter int ROWS     = 16,
   parameter int COLS     = 16,
   parameter int ROW_AW   = 4,
   parameter int GEN_W    = 9,
   parameter int WIN_GENS = 50
) (
   input  logic              clka,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              restart,
   output logic              rd_en,
   output logic [ROW_AW-1:0] rd_addr,
   input  logic [COLS-1:0]   rd_data,
   output logic [COLS-1:0]   win_above,
   output logic [COLS-1:0]   win_mid,
   output logic [COLS-1:0]   win_below,
   output logic              calc_valid,
   input  logic [COLS-1:0]   calc_row,
   output logic              wr_en,
   output logic [ROW_AW-1:0] wr_addr,
   output logic [COLS-1:0]   wr_data,
   output logic              bank_sel,
   output logic              busy,
   output logic              gen_done,
   output logic [GEN_W-1:0]  gen_count,
   output logic              win,
   output logic              lose,
   output logic [3:0]        state_dbg
);

   // Memory strobes have no back-pressure: rd_en returns rd_data exactly one cycle
   // later, and wr_en commits wr_data to wr_addr of bank ~bank_sel on the same edge.

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_PRIME0 = 4'd1,
      S_PRIME1 = 4'd2,
      S_PRIME2 = 4'd3,
      S_PRIME3 = 4'd4,
      S_CALC   = 4'd5,
      S_SHIFT  = 4'd6,
      S_SWAP   = 4'd7,
      S_WIN    = 4'd8,
      S_LOSE   = 4'd9
   } state_t;

   localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);
   localparam logic [ROW_AW:0]   ROWS_EXT = (ROW_AW + 1)'(ROWS);

   state_t            state;
   state_t            state_nxt;
   logic [ROW_AW-1:0] row_idx;
   logic [ROW_AW:0]   row_p2;
   logic              changed;
   logic              alive;
   logic [GEN_W-1:0]  gen_inc;
   logic              lose_cond;
   logic              win_cond;
   logic              clear_game;

   // Look-ahead row wraps at ROWS, which need not be a power of two.
   assign row_p2    = {1'b0, row_idx} + (ROW_AW + 1)'(2);
   assign gen_inc   = (&gen_count) ? gen_count : gen_count + GEN_W'(1);
   assign lose_cond = !alive || !changed;
   assign win_cond  = (gen_inc == GEN_W'(WIN_GENS));
   assign wr_data   = wr_en ? calc_row : '0;
   assign state_dbg = state;

   always_ff @(posedge clka or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      rd_en      = 1'b0;
      rd_addr    = '0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      calc_valid = 1'b0;
      gen_done   = 1'b0;
      busy       = 1'b0;
      clear_game = 1'b0;
      case (state)
         S_IDLE: begin
            if (restart)    clear_game = 1'b1;
            else if (start) state_nxt  = S_PRIME0;
         end
         S_PRIME0: begin
            busy      = 1'b1;
            rd_en     = 1'b1;
            rd_addr   = LAST_ROW;
            state_nxt = S_PRIME1;
         end
         S_PRIME1: begin
            busy      = 1'b1;
            rd_en     = 1'b1;
            rd_addr   = '0;
            state_nxt = S_PRIME2;
         end
         S_PRIME2: begin
            busy      = 1'b1;
            rd_en     = 1'b1;
            rd_addr   = ROW_AW'(1);
            state_nxt = S_PRIME3;
         end
         S_PRIME3: begin
            busy      = 1'b1;
            state_nxt = S_CALC;
         end
         S_CALC: begin
            busy       = 1'b1;
            calc_valid = 1'b1;
            wr_en      = 1'b1;
            wr_addr    = row_idx;
            if (row_idx != LAST_ROW) begin
               rd_en     = 1'b1;
               rd_addr   = (row_p2 >= ROWS_EXT) ? ROW_AW'(row_p2 - ROWS_EXT) : ROW_AW'(row_p2);
               state_nxt = S_SHIFT;
            end else begin
               state_nxt = S_SWAP;
            end
         end
         S_SHIFT: begin
            busy      = 1'b1;
            state_nxt = S_CALC;
         end
         S_SWAP: begin
            busy     = 1'b1;
            gen_done = 1'b1;
            if (lose_cond)     state_nxt = S_LOSE;
            else if (win_cond) state_nxt = S_WIN;
            else               state_nxt = S_IDLE;
         end
         S_WIN, S_LOSE: begin
            if (restart) begin
               clear_game = 1'b1;
               state_nxt  = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      // The commit in SWAP is atomic; abort only cancels the streaming phase.
      if (abort && busy && (state != S_SWAP)) state_nxt = S_IDLE;
   end

   always_ff @(posedge clka or negedge reset) begin
      if (!reset) begin
         win_above <= '0;
         win_mid   <= '0;
         win_below <= '0;
         row_idx   <= '0;
         changed   <= 1'b0;
         alive     <= 1'b0;
         bank_sel  <= 1'b0;
         gen_count <= '0;
         win       <= 1'b0;
         lose      <= 1'b0;
      end else begin
         case (state)
            S_PRIME1: win_above <= rd_data;
            S_PRIME2: win_mid   <= rd_data;
            S_PRIME3: begin
               win_below <= rd_data;
               row_idx   <= '0;
               changed   <= 1'b0;
               alive     <= 1'b0;
            end
            S_CALC: begin
               changed <= changed | (calc_row != win_mid);
               alive   <= alive | (|calc_row);
            end
            S_SHIFT: begin
               win_above <= win_mid;
               win_mid   <= win_below;
               win_below <= rd_data;
               row_idx   <= row_idx + ROW_AW'(1);
            end
            S_SWAP: begin
               bank_sel  <= ~bank_sel;
               gen_count <= gen_inc;
               if (lose_cond)     lose <= 1'b1;
               else if (win_cond) win  <= 1'b1;
            end
            default: ;
         endcase
         if (clear_game) begin
            gen_count <= '0;
            bank_sel  <= 1'b0;
            win       <= 1'b0;
            lose      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Directed bench for life_gen_sequencer: two-bank row memory model plus a selectable
// row datapath (invert / still life / extinction), with hand-computed expectations.
module tb_life_gen_sequencer;

   localparam int ROWS     = 16;
   localparam int COLS     = 16;
   localparam int ROW_AW   = 4;
   localparam int GEN_W    = 9;
   localparam int WIN_GENS = 3;

   localparam int ST_IDLE = 0;
   localparam int ST_CALC = 5;
   localparam int ST_WIN  = 8;
   localparam int ST_LOSE = 9;

   // clock / reset
   logic clka = 1'b0;
   logic reset = 1'b0;
   always #5 clka = ~clka;

   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              restart = 1'b0;
   logic              rd_en;
   logic [ROW_AW-1:0] rd_addr;
   logic [COLS-1:0]   rd_data;
   logic [COLS-1:0]   win_above, win_mid, win_below;
   logic              calc_valid;
   logic [COLS-1:0]   calc_row;
   logic              wr_en;
   logic [ROW_AW-1:0] wr_addr;
   logic [COLS-1:0]   wr_data;
   logic              bank_sel, busy, gen_done, win, lose;
   logic [GEN_W-1:0]  gen_count;
   logic [3:0]        state_dbg;

   int mode = 0;  // 0: invert row, 1: still life, 2: extinction

   life_gen_sequencer #(
      .ROWS(ROWS), .COLS(COLS), .ROW_AW(ROW_AW), .GEN_W(GEN_W), .WIN_GENS(WIN_GENS)
   ) dut (
      .clka(clka), .reset(reset), .start(start), .abort(abort), .restart(restart),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .win_above(win_above), .win_mid(win_mid), .win_below(win_below),
      .calc_valid(calc_valid), .calc_row(calc_row),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .bank_sel(bank_sel), .busy(busy), .gen_done(gen_done), .gen_count(gen_count),
      .win(win), .lose(lose), .state_dbg(state_dbg)
   );

   function automatic logic [COLS-1:0] pattern(input int i);
      return COLS'(i * 32'h1357 + 32'h0F01);
   endfunction

   // board memory: bank 0 is reloaded with the pattern while reset is held
   logic [COLS-1:0] mem [2][ROWS];
   always @(posedge clka or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ROWS; i++) begin
            mem[0][i] <= pattern(i);
            mem[1][i] <= '0;
         end
         rd_data <= '0;
      end else begin
         if (rd_en) rd_data <= mem[bank_sel][rd_addr];
         if (wr_en) mem[~bank_sel][wr_addr] <= wr_data;
      end
   end

   always_comb begin
      calc_row = ~win_mid;
      if (mode == 1)      calc_row = win_mid;
      else if (mode == 2) calc_row = '0;
   end

   // scoreboard
   int n_tests = 0;
   int n_fail  = 0;
   logic [ROW_AW-1:0] rd_q[$];
   logic [ROW_AW-1:0] wr_a_q[$];
   logic [COLS-1:0]   wr_d_q[$];
   logic [COLS-1:0]   exp_q[$];
   logic [COLS-1:0]   first_above, first_mid, first_below;
   int n_valid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rd_en"}, rd_en, 0);
      check({tag, "_rd_addr"}, rd_addr, 0);
      check({tag, "_wr_en"}, wr_en, 0);
      check({tag, "_wr_addr"}, wr_addr, 0);
      check({tag, "_wr_data"}, wr_data, 0);
      check({tag, "_above"}, win_above, 0);
      check({tag, "_mid"}, win_mid, 0);
      check({tag, "_below"}, win_below, 0);
      check({tag, "_calc_valid"}, calc_valid, 0);
      check({tag, "_bank_sel"}, bank_sel, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_gen_done"}, gen_done, 0);
      check({tag, "_gen_count"}, gen_count, 0);
      check({tag, "_win"}, win, 0);
      check({tag, "_lose"}, lose, 0);
      check({tag, "_state"}, state_dbg, ST_IDLE);
   endtask

   // driver: one start pulse, then log strobes per cycle until gen_done or abort
   task automatic run_gen(input int abort_cycle, output int done_cyc);
      rd_q.delete();
      wr_a_q.delete();
      wr_d_q.delete();
      n_valid  = 0;
      done_cyc = -1;
      @(negedge clka);
      start = 1'b1;
      @(negedge clka);
      start = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (c > 1) @(negedge clka);
         if (rd_en) rd_q.push_back(rd_addr);
         if (wr_en) begin
            wr_a_q.push_back(wr_addr);
            wr_d_q.push_back(wr_data);
         end
         if (calc_valid) begin
            if (n_valid == 0) begin
               first_above = win_above;
               first_mid   = win_mid;
               first_below = win_below;
            end
            n_valid++;
         end
         if (gen_done) begin
            done_cyc = c;
            break;
         end
         if (c == abort_cycle) begin
            abort = 1'b1;
            @(negedge clka);
            abort = 1'b0;
            break;
         end
      end
   endtask

   task automatic post_check(input string tag, input logic exp_bs, input int exp_cnt,
                             input logic exp_win, input logic exp_lose, input int exp_state);
      @(negedge clka);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_gen_done"}, gen_done, 0);
      check({tag, "_bank_sel"}, bank_sel, exp_bs);
      check({tag, "_gen_count"}, gen_count, exp_cnt);
      check({tag, "_win"}, win, exp_win);
      check({tag, "_lose"}, lose, exp_lose);
      check({tag, "_state"}, state_dbg, exp_state);
   endtask

   task automatic start_ignored(input string tag, input int exp_state);
      logic seen;
      seen = 1'b0;
      @(negedge clka);
      start = 1'b1;
      repeat (4) begin
         @(negedge clka);
         seen = seen | rd_en | busy;
      end
      start = 1'b0;
      check({tag, "_no_activity"}, seen, 0);
      check({tag, "_state"}, state_dbg, exp_state);
   endtask

   task automatic do_restart(input string tag);
      @(negedge clka);
      restart = 1'b1;
      @(negedge clka);
      restart = 1'b0;
      check({tag, "_state"}, state_dbg, ST_IDLE);
      check({tag, "_win"}, win, 0);
      check({tag, "_lose"}, lose, 0);
      check({tag, "_gen_count"}, gen_count, 0);
      check({tag, "_bank_sel"}, bank_sel, 0);
   endtask

   initial begin
      int done;
      int pulses;

      // reset state
      repeat (3) @(negedge clka);
      check_reset_vals("rst");
      reset = 1'b1;

      // full generation with inverting datapath: addresses, data, window, latency
      mode = 0;
      run_gen(-1, done);
      check("g1_done_cycle", done, 36);
      check("g1_rd_count", rd_q.size(), 18);
      for (int i = 0; i < 18 && i < rd_q.size(); i++)
         check($sformatf("g1_rd_addr%0d", i), rd_q[i], (i == 0) ? 15 : (i - 1) % ROWS);
      exp_q.delete();
      for (int i = 0; i < ROWS; i++) exp_q.push_back(~pattern(i));
      check("g1_wr_count", wr_a_q.size(), ROWS);
      for (int i = 0; i < ROWS && i < wr_a_q.size(); i++) begin
         check($sformatf("g1_wr_addr%0d", i), wr_a_q[i], i);
         check($sformatf("g1_wr_data%0d", i), wr_d_q[i], exp_q[i]);
      end
      check("g1_valid_cycles", n_valid, ROWS);
      check("g1_first_above", first_above, pattern(15));
      check("g1_first_mid", first_mid, pattern(0));
      check("g1_first_below", first_below, pattern(1));
      post_check("g1_post", 1'b1, 1, 1'b0, 1'b0, ST_IDLE);

      // abort while writing row 5
      run_gen(15, done);
      check("ab_no_done", done, -1);
      check("ab_last_wr", (wr_a_q.size() > 0) ? wr_a_q[wr_a_q.size() - 1] : 4'hF, 5);
      check("ab_busy", busy, 0);
      check("ab_state", state_dbg, ST_IDLE);
      pulses = 0;
      repeat (40) begin
         @(negedge clka);
         pulses += int'(gen_done) + int'(busy);
      end
      check("ab_quiet", pulses, 0);
      check("ab_bank_sel", bank_sel, 1);
      check("ab_gen_count", gen_count, 1);
      run_gen(-1, done);
      check("ab_regen_done", done, 36);
      post_check("ab_regen_post", 1'b0, 2, 1'b0, 1'b0, ST_IDLE);

      // extinction on the generation that also reaches WIN_GENS: lose wins
      mode = 2;
      run_gen(-1, done);
      check("ext_done", done, 36);
      post_check("ext_post", 1'b1, 3, 1'b0, 1'b1, ST_LOSE);
      start_ignored("ext_start", ST_LOSE);
      do_restart("ext_restart");

      // still life
      mode = 1;
      run_gen(-1, done);
      check("still_done", done, 36);
      post_check("still_post", 1'b1, 1, 1'b0, 1'b1, ST_LOSE);
      start_ignored("still_start", ST_LOSE);
      do_restart("still_restart");

      // win after WIN_GENS generations
      mode = 0;
      run_gen(-1, done);
      check("win1_done", done, 36);
      post_check("win1_post", 1'b1, 1, 1'b0, 1'b0, ST_IDLE);
      run_gen(-1, done);
      check("win2_done", done, 36);
      post_check("win2_post", 1'b0, 2, 1'b0, 1'b0, ST_IDLE);
      run_gen(-1, done);
      check("win3_done", done, 36);
      post_check("win3_post", 1'b1, 3, 1'b1, 1'b0, ST_WIN);
      start_ignored("win_start", ST_WIN);
      do_restart("win_restart");

      // reset asserted mid-CALC
      run_gen(-1, done);
      post_check("pre_rst_post", 1'b1, 1, 1'b0, 1'b0, ST_IDLE);
      @(negedge clka);
      start = 1'b1;
      @(negedge clka);
      start = 1'b0;
      repeat (8) @(negedge clka);
      check("mid_state_calc", state_dbg, ST_CALC);
      #2 reset = 1'b0;
      #1 check_reset_vals("midrst");
      @(negedge clka);
      reset = 1'b1;
      run_gen(-1, done);
      check("midrst_regen_done", done, 36);
      post_check("midrst_regen_post", 1'b1, 1, 1'b0, 1'b0, ST_IDLE);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
